// File: rtl/spart_tx_sched.sv
// Transmit scheduler for the SPART transmitter: two-requester arbitration, launch/complete tracking, divisor register.
// Build option: define SPART_SCHED_FIXED_PRIO_EN for fixed host priority instead of round-robin.
module spart_tx_sched #(
  parameter logic [15:0] DIV_RESET  = 16'd5208,
  parameter int unsigned LAUNCH_TMO = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req_data0,
  input  logic [7:0]  req_data1,
  output logic [1:0]  req_ready,
  input  logic        cfg_we,
  input  logic        cfg_addr,
  input  logic [7:0]  cfg_wdata,
  input  logic        tbr,
  output logic        tx_begin,
  output logic [7:0]  transmit_buffer,
  output logic [15:0] divisor_buffer,
  output logic        busy,
  output logic        last_grant,
  output logic        launch_err,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CFG       = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(LAUNCH_TMO - 1);

  state_t      state_q, state_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic [15:0] div_q, div_d;
  logic [15:0] shadow_q, shadow_d;
  logic        cfg_pending_q, cfg_pending_d;
  logic        last_grant_q, last_grant_d;
  logic        launch_err_q, launch_err_d;
  logic [15:0] frames_q, frames_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        grant_idx_s;

  // Arbitration choice; only consulted in IDLE when some requester is valid.
  always_comb begin
    grant_idx_s = 1'b0;
`ifdef SPART_SCHED_FIXED_PRIO_EN
    if (req_valid[0]) begin
      grant_idx_s = 1'b0;
    end else begin
      grant_idx_s = 1'b1;
    end
`else
    if (req_valid == 2'b11) begin
      grant_idx_s = ~last_grant_q;
    end else if (req_valid[0]) begin
      grant_idx_s = 1'b0;
    end else begin
      grant_idx_s = 1'b1;
    end
`endif
  end

  // Shadow divisor accepts writes in any state; a write in the CFG cycle keeps the request pending.
  always_comb begin
    shadow_d      = shadow_q;
    cfg_pending_d = cfg_pending_q;
    if (cfg_we) begin
      if (cfg_addr) begin
        shadow_d[15:8] = cfg_wdata;
      end else begin
        shadow_d[7:0] = cfg_wdata;
      end
      cfg_pending_d = 1'b1;
    end else if (state_q == S_CFG) begin
      cfg_pending_d = 1'b0;
    end else begin
      cfg_pending_d = cfg_pending_q;
    end
  end

  // Next-state and datapath updates for the launch/complete sequence.
  always_comb begin
    state_d      = state_q;
    tx_buf_d     = tx_buf_q;
    div_d        = div_q;
    last_grant_d = last_grant_q;
    launch_err_d = launch_err_q;
    frames_d     = frames_q;
    tmo_cnt_d    = tmo_cnt_q;
    req_ready    = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (cfg_pending_q) begin
          state_d = S_CFG;
        end else if (tbr && (req_valid != 2'b00)) begin
          req_ready    = grant_idx_s ? 2'b10 : 2'b01;
          tx_buf_d     = grant_idx_s ? req_data1 : req_data0;
          last_grant_d = grant_idx_s;
          state_d      = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CFG: begin
        div_d   = shadow_q;
        state_d = S_IDLE;
      end
      S_LAUNCH: begin
        tmo_cnt_d = 8'd0;
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tbr) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          launch_err_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (tbr) begin
          frames_d = frames_q + 16'd1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tx_buf_q      <= 8'h00;
      div_q         <= DIV_RESET;
      shadow_q      <= DIV_RESET;
      cfg_pending_q <= 1'b0;
      last_grant_q  <= 1'b1;
      launch_err_q  <= 1'b0;
      frames_q      <= 16'd0;
      tmo_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      tx_buf_q      <= tx_buf_d;
      div_q         <= div_d;
      shadow_q      <= shadow_d;
      cfg_pending_q <= cfg_pending_d;
      last_grant_q  <= last_grant_d;
      launch_err_q  <= launch_err_d;
      frames_q      <= frames_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign tx_begin        = (state_q == S_LAUNCH);
  assign busy            = (state_q != S_IDLE);
  assign transmit_buffer = tx_buf_q;
  assign divisor_buffer  = div_q;
  assign last_grant      = last_grant_q;
  assign launch_err      = launch_err_q;
  assign frames_sent     = frames_q;

endmodule
